frame_writer: RTL and testbench

FRAME_WRITER -- requirements
Module: frame_writer

---
 rtl/frame_writer_pkg.sv | 7 +
 rtl/frame_writer_raster_addr_gen.sv | 38 +++
 rtl/frame_writer.sv | 115 +++++++++++
 tb/tb_frame_writer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/frame_writer_pkg.sv
// frame_writer_pkg: pixel format, default frame geometry and capture states shared with the display reader.
package frame_writer_pkg;
   localparam int PIX_W   = 8;
   localparam int FRAME_W = 256;
   localparam int FRAME_H = 256;
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT_SOF, ST_WRITE, ST_DONE} fw_state_e;
endpackage

// File: rtl/frame_writer_raster_addr_gen.sv
// raster_addr_gen: column/row raster counter; addr = {row, col}.
// clr restarts at pixel 0 and inc advances, so clr with inc lands on pixel 1.
module raster_addr_gen #(
   parameter int W  = 256,
   parameter int H  = 256,
   parameter int AW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          inc,
   output logic [AW-1:0] addr,
   output logic          last
);
   localparam int CW = $clog2(W);
   localparam int RW = $clog2(H);
   logic [CW-1:0] col_q, col_d, col_b;
   logic [RW-1:0] row_q, row_d, row_b;
   logic          col_end;
   always_comb begin
      col_b   = clr ? '0 : col_q;
      row_b   = clr ? '0 : row_q;
      col_end = col_b == CW'(W - 1);
      col_d   = inc ? (col_end ? '0 : col_b + 1'b1) : col_b;
      row_d   = (inc && col_end) ? row_b + 1'b1 : row_b;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end
   assign addr = {row_q, col_q};
   assign last = &{row_q, col_q};
endmodule

// File: rtl/frame_writer.sv
// frame_writer: captures one raster frame from a pixel stream into a frame buffer.
// FRAME_WRITER_DOUBLE_BUF_EN adds a second bank, swapped on the next vblank after a frame.
module frame_writer
   import frame_writer_pkg::*;
#(
   parameter int W  = FRAME_W,
   parameter int H  = FRAME_H,
   parameter int AW = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [PIX_W-1:0] s_data,
   input  logic             s_sof,
   output logic             mem_we,
`ifdef FRAME_WRITER_DOUBLE_BUF_EN
   output logic [AW:0]      mem_addr,
   input  logic             vblank,
   output logic             rd_bank,
`else
   output logic [AW-1:0]    mem_addr,
`endif
   output logic [PIX_W-1:0] mem_wdata,
   output logic             busy,
   output logic             frame_done,
   output logic             err_sof
);
   fw_state_e        state_q, state_d;
   logic             acc, sof_acc, wr_en, last_beat, start_ok, cnt_last;
   logic             err_sof_q, err_sof_d, mem_we_q;
   logic [AW-1:0]    cnt_addr, wr_addr;
   logic [PIX_W-1:0] mem_wdata_q;
`ifdef FRAME_WRITER_DOUBLE_BUF_EN
   logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, swap_q, swap_d, flip;
   logic [AW:0]      mem_addr_q, mem_addr_d;
   // A finished frame stays on display hold until the reader is in vblank.
   always_comb begin
      flip       = vblank & swap_q;
      swap_d     = frame_done | (swap_q & ~vblank);
      wr_bank_d  = wr_bank_q ^ flip;
      rd_bank_d  = rd_bank_q ^ flip;
      start_ok   = start & ~swap_q;
      mem_addr_d = {wr_bank_q, wr_addr};
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_bank_q <= 1'b1;
         rd_bank_q <= 1'b0;
         swap_q    <= 1'b0;
      end else begin
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         swap_q    <= swap_d;
      end
   end
   assign rd_bank = rd_bank_q;
`else
   logic [AW-1:0]    mem_addr_q, mem_addr_d;
   assign start_ok   = start;
   assign mem_addr_d = wr_addr;
`endif
   assign acc       = s_valid & s_ready;
   assign sof_acc   = acc & s_sof;
   assign wr_en     = sof_acc | (acc & (state_q == ST_WRITE));
   assign wr_addr   = sof_acc ? '0 : cnt_addr;
   assign last_beat = acc & ~s_sof & cnt_last & (state_q == ST_WRITE);
   raster_addr_gen #(.W(W), .H(H), .AW(AW)) u_addr (
      .clk  (clk),
      .reset(reset),
      .clr  (sof_acc),
      .inc  (wr_en),
      .addr (cnt_addr),
      .last (cnt_last)
   );
   always_ff @(posedge clk) begin
      state_q <= reset ? ST_IDLE : state_d;
   end
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:     state_d = start_ok ? ST_WAIT_SOF : ST_IDLE;
         ST_WAIT_SOF: state_d = sof_acc ? ST_WRITE : ST_WAIT_SOF;
         ST_WRITE:    state_d = last_beat ? ST_DONE : ST_WRITE;
         ST_DONE:     state_d = ST_IDLE;
      endcase
   end
   always_comb begin
      s_ready    = (state_q == ST_WAIT_SOF) || (state_q == ST_WRITE);
      busy       = (state_q == ST_WAIT_SOF) || (state_q == ST_WRITE);
      frame_done = state_q == ST_DONE;
   end
   assign err_sof_d = (state_q == ST_IDLE && start_ok) ? 1'b0 :
                      (state_q == ST_WRITE && sof_acc) ? 1'b1 : err_sof_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         err_sof_q   <= 1'b0;
      end else begin
         mem_we_q  <= wr_en;
         err_sof_q <= err_sof_d;
         if (wr_en) begin
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= s_data;
         end
      end
   end
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign err_sof   = err_sof_q;
endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: 4x4 frame capture against a frame-level reference model plus directed corner cases.
module tb_frame_writer;
   localparam int W = 4, H = 4, AW = 4, N = W * H;
`ifdef FRAME_WRITER_DOUBLE_BUF_EN
   localparam int MAW = AW + 1;
   logic vblank = 1'b0, rd_bank;
`else
   localparam int MAW = AW;
`endif
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, s_valid = 1'b0, s_sof = 1'b0;
   logic [7:0] s_data = 8'h00, mem_wdata;
   logic [MAW-1:0] mem_addr;
   logic s_ready, mem_we, busy, frame_done, err_sof;
   int n_cmp = 0, n_bad = 0, n_done = 0, n_we = 0;
   int m_phase = 0, m_idx = 0;
   bit m_err = 0, m_bank = 1, m_rd = 0, m_swap = 0;

   always #5 clk = ~clk;

   frame_writer #(.W(W), .H(H), .AW(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_sof(s_sof), .mem_we(mem_we), .mem_addr(mem_addr),
`ifdef FRAME_WRITER_DOUBLE_BUF_EN
      .vblank(vblank), .rd_bank(rd_bank),
`endif
      .mem_wdata(mem_wdata), .busy(busy), .frame_done(frame_done), .err_sof(err_sof)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // One clock of stimulus; the model tracks the frame as phase + pixel index.
   task automatic cycle(input logic st, input logic v, input logic sf, input logic [7:0] d);
      int ph;
      bit rdy, we, blocked, wb;
      logic [MAW-1:0] a;
      start = st; s_valid = v; s_sof = sf; s_data = d;
      @(posedge clk);
      ph = m_phase; rdy = (ph == 1 || ph == 2); we = 0; a = '0;
      blocked = m_swap; wb = m_bank;
`ifdef FRAME_WRITER_DOUBLE_BUF_EN
      if (vblank && m_swap) begin m_bank = ~m_bank; m_rd = ~m_rd; m_swap = 0; end
      if (ph == 3) m_swap = 1;
`else
      blocked = 0;
`endif
      if (v && rdy) begin
         if (sf) begin
            if (ph == 2) m_err = 1;
            we = 1; m_idx = 1; m_phase = 2;
         end else if (ph == 2) begin
            we = 1; a = MAW'(m_idx); m_idx++;
            if (m_idx == N) m_phase = 3;
         end
      end
      if (ph == 0 && st && !blocked) begin m_phase = 1; m_err = 0; end
      if (ph == 3) m_phase = 0;
`ifdef FRAME_WRITER_DOUBLE_BUF_EN
      if (we) a[AW] = wb;
`endif
      @(negedge clk);
      if (mem_we) n_we++;
      if (frame_done) n_done++;
      rdy = (m_phase == 1 || m_phase == 2);
      check("cycle", 32'({mem_we, mem_we ? mem_addr : '0, mem_we ? mem_wdata : 8'h00, frame_done, s_ready, busy, err_sof}),
            32'({we, a, we ? d : 8'h00, m_phase == 3, rdy, rdy, m_err}));
`ifdef FRAME_WRITER_DOUBLE_BUF_EN
      check("rd_bank", 32'(rd_bank), 32'(m_rd));
`endif
   endtask

   task automatic do_reset();
      reset = 1; start = 0; s_valid = 0; s_sof = 0;
      @(posedge clk);
      m_phase = 0; m_idx = 0; m_err = 0; m_bank = 1; m_rd = 0; m_swap = 0;
      @(negedge clk);
      reset = 0;
      check("reset", 32'({mem_we, mem_addr, mem_wdata, frame_done, s_ready, busy, err_sof}), 32'h0);
`ifdef FRAME_WRITER_DOUBLE_BUF_EN
      check("reset_rd_bank", 32'(rd_bank), 32'h0);
`endif
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
`ifdef FRAME_WRITER_DOUBLE_BUF_EN
         vblank = (i == 1);
`endif
         cycle(0, 0, 0, 8'h00);
      end
`ifdef FRAME_WRITER_DOUBLE_BUF_EN
      vblank = 0;
`endif
   endtask

   typedef struct {
      logic st, v, sf; logic [7:0] d;
      logic we; logic [3:0] addr; logic [7:0] data; logic done, rdy, bsy, err;
   } vec_t;
   vec_t tbl[9];

   initial begin
      int d0, w0, b;
      tbl[0] = '{1, 0, 0, 8'h00, 0, 4'h0, 8'h00, 0, 1, 1, 0};
      tbl[1] = '{0, 1, 0, 8'hAA, 0, 4'h0, 8'h00, 0, 1, 1, 0};
      tbl[2] = '{0, 1, 0, 8'hBB, 0, 4'h0, 8'h00, 0, 1, 1, 0};
      tbl[3] = '{0, 1, 0, 8'hCC, 0, 4'h0, 8'h00, 0, 1, 1, 0};
      tbl[4] = '{0, 1, 1, 8'h50, 1, 4'h0, 8'h50, 0, 1, 1, 0};
      tbl[5] = '{0, 1, 0, 8'h51, 1, 4'h1, 8'h51, 0, 1, 1, 0};
      tbl[6] = '{0, 0, 0, 8'h00, 0, 4'h0, 8'h00, 0, 1, 1, 0};
      tbl[7] = '{0, 1, 0, 8'h52, 1, 4'h2, 8'h52, 0, 1, 1, 0};
      tbl[8] = '{1, 0, 0, 8'h00, 0, 4'h0, 8'h00, 0, 1, 1, 0};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         cycle(tbl[i].st, tbl[i].v, tbl[i].sf, tbl[i].d);
         check($sformatf("tbl%0d", i),
               32'({mem_we, mem_we ? mem_addr[AW-1:0] : 4'h0, mem_we ? mem_wdata : 8'h00, frame_done, s_ready, busy, err_sof}),
               32'({tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].done, tbl[i].rdy, tbl[i].bsy, tbl[i].err}));
      end
      do_reset();
      // Full continuous frame.
      d0 = n_done; w0 = n_we;
      cycle(1, 0, 0, 8'h00);
      for (int i = 0; i < N; i++) cycle(0, 1, i == 0, 8'(8'h10 + i));
      check("full_done_now", 32'({frame_done, mem_we, mem_addr[AW-1:0], mem_wdata}), 32'({1'b1, 1'b1, 4'hF, 8'h1F}));
      idle(3);
      check("full_done_cnt", 32'(n_done - d0), 32'd1);
      check("full_writes", 32'(n_we - w0), 32'(N));
      // Stalled frame: valid pattern 1,0,0,1.
      d0 = n_done; w0 = n_we; b = 0;
      cycle(1, 0, 0, 8'h00);
      for (int k = 0; b < N && k < 200; k++) begin
         logic v;
         v = (k % 4 == 0) || (k % 4 == 3);
         cycle(0, v, v && b == 0, 8'(8'h40 + b));
         if (v) b++;
      end
      idle(3);
      check("stall_writes", 32'(n_we - w0), 32'(N));
      check("stall_done_cnt", 32'(n_done - d0), 32'd1);
      // Early SOF on beat 7.
      d0 = n_done;
      cycle(1, 0, 0, 8'h00);
      for (int i = 0; i < 7; i++) cycle(0, 1, i == 0, 8'(8'h60 + i));
      cycle(0, 1, 1, 8'h99);
      check("early_sof_err", 32'({err_sof, mem_we, mem_addr[AW-1:0]}), 32'({1'b1, 1'b1, 4'h0}));
      for (int i = 0; i < N - 2; i++) cycle(0, 1, 0, 8'(8'h70 + i));
      check("early_sof_not_done", 32'(n_done - d0), 32'd0);
      cycle(0, 1, 0, 8'h7F);
      check("early_sof_done", 32'(n_done - d0), 32'd1);
      idle(3);
      cycle(1, 0, 0, 8'h00);
      check("start_clears_err", 32'({err_sof, busy}), 32'({1'b0, 1'b1}));
      // Reset at beat 9, then a clean frame.
      d0 = n_done;
      for (int i = 0; i < 9; i++) cycle(0, 1, i == 0, 8'(8'h80 + i));
      do_reset();
      check("reset_no_done", 32'(n_done - d0), 32'd0);
      cycle(1, 0, 0, 8'h00);
      cycle(0, 1, 1, 8'hA0);
      check("after_reset_addr0", 32'({mem_we, mem_addr[AW-1:0], mem_wdata}), 32'({1'b1, 4'h0, 8'hA0}));
      for (int i = 1; i < N; i++) cycle(0, 1, 0, 8'(8'hA0 + i));
      check("after_reset_done", 32'(n_done - d0), 32'd1);
      idle(3);
`ifdef FRAME_WRITER_DOUBLE_BUF_EN
      // Bank swap waits for vblank; start before it is ignored.
      do_reset();
      cycle(1, 0, 0, 8'h00);
      cycle(0, 1, 1, 8'hC0);
      check("bank1_write", 32'({mem_we, mem_addr[AW]}), 32'({1'b1, 1'b1}));
      for (int i = 1; i < N; i++) cycle(0, 1, 0, 8'(8'hC0 + i));
      cycle(0, 0, 0, 8'h00);
      cycle(0, 0, 0, 8'h00);
      cycle(1, 0, 0, 8'h00);
      check("start_blocked", 32'({busy, rd_bank}), 32'({1'b0, 1'b0}));
      vblank = 1;
      cycle(0, 0, 0, 8'h00);
      vblank = 0;
      check("rd_bank_swapped", 32'(rd_bank), 32'h1);
      cycle(1, 0, 0, 8'h00);
      cycle(0, 1, 1, 8'hD0);
      check("bank0_write", 32'({mem_we, mem_addr[AW]}), 32'({1'b1, 1'b0}));
      do_reset();
`endif
      // Random traffic against the model.
      for (int i = 0; i < 800; i++) begin
`ifdef FRAME_WRITER_DOUBLE_BUF_EN
         vblank = ($urandom_range(0, 7) == 0);
`endif
         cycle($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, 8'($urandom));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1);
   end
endmodule
